pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised program-counter unit for the IF stage; successor to the plain PC register.
- Owns the fetch PC and computes the sequential next PC internally.
- Arbitrates exception, branch and jump redirects by fixed priority.
- Holds the PC under stall; a redirect that arrives during a stall is buffered and applied when the stall releases.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- EXC_VEC, 32'h0000_0080, exception handler target.
- INSTR_BYTES, 4, sequential increment; power of two, at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC; the pipeline cannot accept a new fetch.
- exc_en  in  1  exception redirect request.
- br_taken  in  1  taken-branch redirect request.
- br_target  in  ADDR_W  branch target.
- jmp_en  in  1  jump redirect request.
- jmp_target  in  ADDR_W  jump target.
- pcout  out  ADDR_W  current fetch PC.
- pcplus  out  ADDR_W  pcout+INSTR_BYTES, combinational.
- pc_valid  out  1  pcout is a valid fetch address.
- redir_pending  out  1  a buffered redirect is waiting on stall release.
- misalign_err  out  1  only with PC_ALIGN_CHECK_EN; one-cycle pulse.

Behaviour:
- Reset: async assert on rst_n low. Reset values:
  - pcout=RESET_VEC
  - pc_valid=0
  - redir_pending=0
  - pending target=0
  - pending priority=0
  - misalign_err=0
  - state=BOOT
- States:
  - BOOT: one cycle after reset release, pc_valid=0, pcout held at RESET_VEC, then RUN. Redirects sampled in BOOT are captured as pending.
  - RUN: pc_valid=1.
  - HOLD: entered when stall=1 at a RUN edge; pc_valid=1, pcout frozen. Returns to RUN on the edge where stall=0.
- Redirect priority: exc_en(3) > br_taken(2) > jmp_en(1) > sequential(0). Selected target:
  - EXC_VEC for exc_en.
  - br_target for br_taken.
  - jmp_target for jmp_en.
- RUN, stall=0, no pending, on each edge: pcout <= selected target if any request, else pcplus. Latency 1 cycle.
- Stall with a request (RUN or HOLD): the request is captured into the pending register if its priority >= stored priority. Ties are resolved in favour of the newer request. redir_pending=1 the next cycle; pcout is unchanged.
- Stall release (stall=0) with pending set: pcout <= pending target; pending and priority are cleared.
  - A request in the same cycle with priority >= pending overrides the pending target.
  - exc_en always wins.
- Wrap-around: pcplus is computed modulo 2^ADDR_W, so 32'hFFFF_FFFC+4 = 0. No flag is raised.
- Alignment (macro off): the low log2(INSTR_BYTES) bits of every loaded target are forced to 0.
- Reset mid-stall or mid-pending: everything returns to reset values immediately; the buffered redirect is discarded.
- pcplus always tracks pcout combinationally, including in BOOT and HOLD.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: a br or jmp target with non-zero low log2(INSTR_BYTES) bits is not loaded. pcout <= EXC_VEC instead, and misalign_err pulses 1 for one cycle at that edge. A misaligned target that is buffered during a stall is checked when it is applied. The misalign_err port exists only in this build.
- Undefined: the port is absent and the low bits are silently masked.

Test Plan:
- Reset then run, RESET_VEC=0, no stall: pcout sequence 0 (pc_valid=0 in BOOT), 0, 4, 8, 0xC with pc_valid=1.
- In RUN at pcout=0x10, br_taken=1 with br_target=0x200 and jmp_en=1 with jmp_target=0x300, same cycle -> next pcout=0x200. Then exc_en+br_taken -> pcout=0x80.
- Stall 3 cycles at pcout=0x20 with jmp_en pulsed in cycle 1 (target 0x400) and br_taken pulsed in cycle 2 (target 0x500):
  - pcout holds 0x20.
  - redir_pending=1 from cycle 2.
  - On release pcout=0x500, then 0x504.
- ADDR_W=32, pcout forced to 0xFFFF_FFFC via jmp -> next pcout=0x0000_0000; pcplus=0x0 while pcout=0xFFFF_FFFC.
- rst_n asserted mid-stall with pending=0x500 -> pcout=0 immediately, redir_pending=0. After release: BOOT, then 0, 4.
- PC_ALIGN_CHECK_EN defined, br_target=0x102 -> pcout=0x80 and misalign_err=1 for exactly one cycle. Undefined build: pcout=0x100.

Source files
------------

// File: rtl/pc_unit.sv
// Fetch program counter with prioritised redirects, stall hold and a one-deep redirect buffer.
// Optional build macro PC_ALIGN_CHECK_EN: misaligned branch/jump targets trap to EXC_VEC and pulse misalign_err.
module pc_unit #(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] EXC_VEC     = 32'h0000_0080,
    parameter int unsigned       INSTR_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              exc_en,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_target,
    output logic [ADDR_W-1:0] pcout,
    output logic [ADDR_W-1:0] pcplus,
    output logic              pc_valid,
    output logic              redir_pending
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic              misalign_err
`endif
);

    localparam logic [ADDR_W-1:0] INCR       = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);
    localparam logic [1:0]        PRIO_EXC   = 2'd3;
    localparam logic [1:0]        PRIO_BR    = 2'd2;
    localparam logic [1:0]        PRIO_JMP   = 2'd1;
    localparam logic [1:0]        PRIO_NONE  = 2'd0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic [1:0]        pend_prio_q, pend_prio_d;

    logic [1:0]        req_prio;
    logic [ADDR_W-1:0] req_tgt;
    logic              apply;
    logic [ADDR_W-1:0] apply_tgt;
`ifdef PC_ALIGN_CHECK_EN
    logic              apply_chk;
    logic              misalign_q, misalign_d;
`endif

    // Fixed-priority request encoder.
    always_comb begin
        req_prio = PRIO_NONE;
        req_tgt  = '0;
        if (exc_en) begin
            req_prio = PRIO_EXC;
            req_tgt  = EXC_VEC;
        end else if (br_taken) begin
            req_prio = PRIO_BR;
            req_tgt  = br_target;
        end else if (jmp_en) begin
            req_prio = PRIO_JMP;
            req_tgt  = jmp_target;
        end
    end

    assign pcplus = pc_q + INCR;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_tgt_d   = pend_tgt_q;
        pend_prio_d  = pend_prio_q;
        apply        = 1'b0;
        apply_tgt    = req_tgt;
`ifdef PC_ALIGN_CHECK_EN
        apply_chk    = (req_prio != PRIO_EXC);
        misalign_d   = 1'b0;
`endif

        // Buffer a request while the pipeline cannot take it; newer wins ties.
        if (state_q == BOOT || stall) begin
            if (req_prio != PRIO_NONE && req_prio >= pend_prio_q) begin
                pend_valid_d = 1'b1;
                pend_tgt_d   = req_tgt;
                pend_prio_d  = req_prio;
            end
        end

        case (state_q)
            BOOT: state_d = RUN;
            RUN, HOLD: begin
                if (stall) begin
                    state_d = HOLD;
                end else begin
                    state_d = RUN;
                    if (pend_valid_q) begin
                        apply        = 1'b1;
                        pend_valid_d = 1'b0;
                        pend_tgt_d   = '0;
                        pend_prio_d  = PRIO_NONE;
                        if (req_prio == PRIO_NONE || req_prio < pend_prio_q) begin
                            apply_tgt = pend_tgt_q;
`ifdef PC_ALIGN_CHECK_EN
                            apply_chk = (pend_prio_q != PRIO_EXC);
`endif
                        end
                    end else if (req_prio != PRIO_NONE) begin
                        apply = 1'b1;
                    end else begin
                        pc_d = pcplus;
                    end
                end
            end
            default: state_d = BOOT;
        endcase

        if (apply) begin
`ifdef PC_ALIGN_CHECK_EN
            if (apply_chk && (apply_tgt & ALIGN_MASK) != '0) begin
                pc_d       = EXC_VEC & ~ALIGN_MASK;
                misalign_d = 1'b1;
            end else begin
                pc_d = apply_tgt & ~ALIGN_MASK;
            end
`else
            pc_d = apply_tgt & ~ALIGN_MASK;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VEC;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= '0;
            pend_prio_q  <= PRIO_NONE;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_tgt_q   <= pend_tgt_d;
            pend_prio_q  <= pend_prio_d;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign pcout         = pc_q;
    assign pc_valid      = (state_q != BOOT);
    assign redir_pending = pend_valid_q;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign_err  = misalign_q;
`endif

endmodule
